alu_issue_scheduler: RTL

Issue queue and scheduler feeding NUM_FU ALU functional units.
- Accepts renamed ALU ops from dispatch and holds them until both source operands are available.
- Captures operands by snooping the FU wakeup buses.
- Each cycle, issues the oldest ready ops to the available FUs, at most one op per FU per cycle.
- Sits between the rename/dispatch stage and the FU array; its FU-side outputs drive the FU issue ports directly.

---
 rtl/alu_issue_scheduler.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/alu_issue_scheduler.sv
// ALU issue queue: holds renamed ops until their operands arrive, then issues the oldest ready ops to free FUs.
// Entries are kept as a collapsing queue. Slot 0 is always the oldest entry, so age needs no counters.
module alu_issue_scheduler #(
    parameter int DEPTH  = 8,
    parameter int NUM_FU = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  alloc_valid,
    output logic                  alloc_ready,
    input  logic [3:0]            alloc_alu_ctrl,
    input  logic                  alloc_alu_src,
    input  logic                  alloc_is_for_lsq,
    input  logic [31:0]           alloc_imm,
    input  logic                  alloc_rs1_ready,
    input  logic [5:0]            alloc_rs1_tag,
    input  logic [31:0]           alloc_rs1_value,
    input  logic                  alloc_rs2_ready,
    input  logic [5:0]            alloc_rs2_tag,
    input  logic [31:0]           alloc_rs2_value,
    input  logic [5:0]            alloc_dest_tag,
    input  logic [5:0]            alloc_rob_index,
    input  logic [NUM_FU-1:0]     wb_active,
    input  logic [6*NUM_FU-1:0]   wb_tag,
    input  logic [32*NUM_FU-1:0]  wb_value,
    input  logic [NUM_FU-1:0]     fu_available,
    output logic [NUM_FU-1:0]     fu_write_enable,
    output logic [4*NUM_FU-1:0]   fu_alu_ctrl,
    output logic [NUM_FU-1:0]     fu_alu_src,
    output logic [NUM_FU-1:0]     fu_is_for_lsq,
    output logic [32*NUM_FU-1:0]  fu_imm,
    output logic [32*NUM_FU-1:0]  fu_rs1_value,
    output logic [32*NUM_FU-1:0]  fu_rs2_value,
    output logic [6*NUM_FU-1:0]   fu_tag,
    output logic [6*NUM_FU-1:0]   fu_rob_index,
    output logic [4:0]            occupancy
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [4:0] DEPTH_L = 5'(DEPTH);

    typedef struct packed {
        logic        ready;
        logic [5:0]  tag;
        logic [31:0] value;
    } src_t;

    typedef struct packed {
        logic        valid;
        logic [3:0]  alu_ctrl;
        logic        alu_src;
        logic        is_for_lsq;
        logic [31:0] imm;
        src_t        rs1;
        src_t        rs2;
        logic [5:0]  dest_tag;
        logic [5:0]  rob_index;
    } entry_t;

    entry_t           entries_q [DEPTH];
    entry_t           entries_d [DEPTH];
    logic [4:0]       occ_q, occ_d;
    logic [DEPTH-1:0] eligible, issue_mask;
    logic [4:0]       issued_count;
    logic             alloc_fire;

    assign occupancy   = occ_q;
    assign alloc_ready = occ_q < DEPTH_L;
    assign alloc_fire  = alloc_valid && alloc_ready && !flush;

    // A waiting source takes the value from the lowest matching wakeup lane. A ready source is never overwritten.
    function automatic src_t snoop(input src_t s);
        src_t r;
        logic hit;
        r   = s;
        hit = s.ready;
        for (int i = 0; i < NUM_FU; i++) begin
            if (!hit && wb_active[i] && wb_tag[i*6 +: 6] == s.tag) begin
                r.ready = 1'b1;
                r.value = wb_value[i*32 +: 32];
                hit     = 1'b1;
            end
        end
        return r;
    endfunction

    always_comb begin
        for (int i = 0; i < DEPTH; i++)
            eligible[i] = entries_q[i].valid && entries_q[i].rs1.ready &&
                          (entries_q[i].alu_src || entries_q[i].rs2.ready);
    end

    // The scan runs from the oldest entry to the youngest. Each eligible entry claims the lowest free FU that is still unclaimed.
    always_comb begin
        logic [NUM_FU-1:0] fu_used;
        logic              taken;
        // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
        fu_used         = '0;
        taken           = 1'b0;
        issue_mask      = '0;
        issued_count    = '0;
        fu_write_enable = '0;
        fu_alu_ctrl     = '0;
        fu_alu_src      = '0;
        fu_is_for_lsq   = '0;
        fu_imm          = '0;
        fu_rs1_value    = '0;
        fu_rs2_value    = '0;
        fu_tag          = '0;
        fu_rob_index    = '0;
        if (!flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                taken = 1'b0;
                for (int j = 0; j < NUM_FU; j++) begin
                    if (eligible[i] && !taken && fu_available[j] && !fu_used[j]) begin
                        taken                 = 1'b1;
                        fu_used[j]            = 1'b1;
                        issue_mask[i]         = 1'b1;
                        issued_count          = issued_count + 5'd1;
                        fu_write_enable[j]    = 1'b1;
                        fu_alu_ctrl[j*4 +: 4] = entries_q[i].alu_ctrl;
                        fu_alu_src[j]         = entries_q[i].alu_src;
                        fu_is_for_lsq[j]      = entries_q[i].is_for_lsq;
                        fu_imm[j*32 +: 32]    = entries_q[i].imm;
                        fu_rs1_value[j*32 +: 32] = entries_q[i].rs1.value;
                        fu_rs2_value[j*32 +: 32] = entries_q[i].rs2.value;
                        fu_tag[j*6 +: 6]      = entries_q[i].dest_tag;
                        fu_rob_index[j*6 +: 6] = entries_q[i].rob_index;
                    end
                end
            end
        end
    end

    // Surviving entries are compacted toward slot 0 with their wakeups applied. The new op goes in just above them.
    always_comb begin
        entry_t     e;
        logic [IW:0] wp;
        e  = '0;
        wp = '0;
        for (int i = 0; i < DEPTH; i++) entries_d[i] = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entries_q[i].valid && !issue_mask[i]) begin
                e     = entries_q[i];
                e.rs1 = snoop(entries_q[i].rs1);
                e.rs2 = snoop(entries_q[i].rs2);
                entries_d[wp[IW-1:0]] = e;
                wp = wp + 1'b1;
            end
        end
        if (alloc_fire) begin
            e.valid      = 1'b1;
            e.alu_ctrl   = alloc_alu_ctrl;
            e.alu_src    = alloc_alu_src;
            e.is_for_lsq = alloc_is_for_lsq;
            e.imm        = alloc_imm;
            e.rs1        = snoop('{alloc_rs1_ready, alloc_rs1_tag, alloc_rs1_value});
            e.rs2        = snoop('{alloc_rs2_ready, alloc_rs2_tag, alloc_rs2_value});
            e.dest_tag   = alloc_dest_tag;
            e.rob_index  = alloc_rob_index;
            entries_d[wp[IW-1:0]] = e;
        end
        if (flush)
            for (int i = 0; i < DEPTH; i++) entries_d[i] = '0;
        occ_d = flush ? 5'd0 : occ_q + {4'd0, alloc_fire} - issued_count;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            occ_q <= '0;
            // NOTE: the payload is cleared along with the valid bits. The queue is small, and idle outputs then stay at 0.
            for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
        end else begin
            // NOTE: registered state uses non-blocking assignments, so every slot updates from the same snapshot.
            occ_q <= occ_d;
            for (int i = 0; i < DEPTH; i++) entries_q[i] <= entries_d[i];
        end
    end

endmodule
